// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the hex scroll controller: FSM states,
// blank-digit pattern and the active-low nibble-to-segment table.
package hex_scroll_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } state_t;

    localparam logic [6:0] BLANK_SEG = 7'h7F;

    // Index n holds the g..a pattern for nibble n; first listed entry is F.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// Nibble write port of the hex scroll controller (valid/ready handshake).
interface hex_scroll_ctrl_if;
    logic       wr_valid;
    logic [3:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/hex_scroll_ctrl_seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_seg
    import hex_scroll_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/hex_scroll_ctrl.sv
// Buffers up to DEPTH nibbles and scrolls them right-to-left across NUM_DIGITS
// seven-segment displays. Define HEX_SCROLL_WRAP_EN to repeat passes until stop.
//
// state  | meaning
// IDLE   | accept writes/clear, displays blank, wait for start with count > 0
// SCROLL | prescaler running, position p advances once per tick
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int DEPTH      = 16,
    parameter int NUM_DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    hex_scroll_ctrl_if.slave          wr,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    count,
    output logic [7*NUM_DIGITS-1:0]   hex_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(DEPTH + NUM_DIGITS);
    localparam int TW = $clog2(TICK_DIV);

    state_t               state, state_n;
    logic [PW-1:0]        pos, pos_n;
    logic [TW-1:0]        presc, presc_n;
    logic [CW-1:0]        count_n;
    logic                 wr_en;
    logic                 tick;
    logic                 last;
    logic [3:0]           buffer [DEPTH];
    logic [7*NUM_DIGITS-1:0] hex_n;

    assign wr.wr_ready = (state == IDLE) && (count < CW'(DEPTH));
    assign tick        = (presc == TW'(TICK_DIV - 1));
    // Final position: last nibble still visible on the leftmost digit.
    assign last        = (pos == PW'(count) + PW'(NUM_DIGITS - 2));

    always_comb begin
        state_n = state;
        pos_n   = pos;
        presc_n = presc;
        count_n = count;
        wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    count_n = '0;
                end else if (wr.wr_valid && wr.wr_ready) begin
                    wr_en   = 1'b1;
                    count_n = count + 1'b1;
                end
                if (start && (count_n != '0)) begin
                    state_n = SCROLL;
                    pos_n   = '0;
                    presc_n = '0;
                end
            end
            SCROLL: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (tick) begin
                    presc_n = '0;
                    if (last) begin
`ifdef HEX_SCROLL_WRAP_EN
                        pos_n = '0;
`else
                        state_n = IDLE;
`endif
                    end else begin
                        pos_n = pos + 1'b1;
                    end
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            pos     <= '0;
            presc   <= '0;
            busy    <= 1'b0;
            hex_out <= {NUM_DIGITS{BLANK_SEG}};
        end else begin
            state   <= state_n;
            count   <= count_n;
            pos     <= pos_n;
            presc   <= presc_n;
            busy    <= (state_n == SCROLL);
            hex_out <= hex_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[count[AW-1:0]] <= wr.wr_data;
        end
    end

    // Digit i shows nibble p - i when that index lies inside the message.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [PW-1:0] k;
        logic          vis;
        logic [6:0]    seg;

        assign k   = pos - PW'(i);
        assign vis = (state == SCROLL) && (pos >= PW'(i)) && (k < PW'(count));

        hex_seg u_seg (
            .nib (buffer[k[AW-1:0]]),
            .seg (seg)
        );

        assign hex_n[7*i +: 7] = vis ? seg : BLANK_SEG;
    end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Scrolling controller for the DE1-SoC seven-segment bank. It buffers a message of up to DEPTH hex nibbles written through a valid/ready port, then on `start` scrolls the message right-to-left across NUM_DIGITS displays at a prescaled rate. It feeds its own nibble-to-segment decoder, so switch-driven decode labs become timed multi-digit output.

## Interface
- TICK_DIV, 25_000_000: clk cycles per scroll step (0.5 s at 50 MHz); legal range ≥2.
- DEPTH, 16: nibble buffer capacity; power of two, ≥2.
- NUM_DIGITS, 6: number of displays driven.
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  nibble write request.
- wr_data  in  4  nibble value.
- wr_ready  out  1  buffer accepts a write this cycle.
- start  in  1  begin scrolling (level sampled each cycle).
- stop  in  1  abort scrolling.
- clear  in  1  empty the buffer (IDLE only).
- busy  out  1  high in SCROLL.
- count  out  $clog2(DEPTH)+1  nibbles currently stored.
- hex_out  out  7*NUM_DIGITS  active-low segments; digit i at bits [7i+6:7i], digit 0 rightmost (HEX0).

## Operation
- States: IDLE, SCROLL.
- IDLE: wr_ready = (count < DEPTH). A write is accepted when wr_valid && wr_ready. It stores wr_data at index count, then count+1. hex_out is all blank (7'h7F per digit).
- clear in IDLE sets count to 0 and takes priority over a same-cycle write. clear is ignored in SCROLL.
- start in IDLE with count > 0 enters SCROLL: position p = 0 and prescaler = 0. start with count = 0 is ignored.
- Same-cycle write and start in IDLE: the write is accepted and the scroll covers the new count.
- SCROLL: wr_ready = 0 and writes are dropped. Digit i shows nibble k = p − i when 0 ≤ k < count, otherwise blank.
- Each prescaler terminal count (TICK_DIV−1) is a tick. On a tick, p increments.
- p range is 0 .. count+NUM_DIGITS−2. This is the last position where nibble count−1 is still visible on digit NUM_DIGITS−1.
- A tick at the final p ends the pass (see Configuration).
- stop in SCROLL returns to IDLE next cycle. count is kept, so a later start replays the message. If stop coincides with a tick, stop wins.
- start while in SCROLL is ignored.
- Nibble decode covers 0–F, active-low segment order g..a = bits 6..0:
  - 0 = 7'h40
  - 1 = 7'h79
  - 8 = 7'h00
  - A = 7'h08
  - F = 7'h0E

## Timing
- Reset values: state IDLE, count 0, p 0, prescaler 0, busy 0, wr_ready 1, hex_out all 7'h7F. Buffer contents are don't-care.
- Reset mid-SCROLL gives the same reset values; the message is lost.
- hex_out and busy are registered. They reflect the state/p of the previous cycle, so there is 1 cycle of latency from a p change to hex_out.
- First display:
  - start accepted in cycle n → busy = 1 and SCROLL in cycle n+1.
  - Nibble 0 on HEX0 from cycle n+2.
- Step spacing: p steps exactly every TICK_DIV cycles after SCROLL entry. The first step is TICK_DIV cycles after entry.
- A full pass lasts (count+NUM_DIGITS−1)·TICK_DIV cycles.
- wr_ready is combinational from state and count.

## Configuration
- HEX_SCROLL_WRAP_EN defined: a tick at the final p sets p = 0 and scrolling repeats until stop or reset. busy stays 1.
- HEX_SCROLL_WRAP_EN undefined: a tick at the final p returns to IDLE. count is retained and displays blank.

## Structure
- Package hex_scroll_pkg:
  - state enum {IDLE, SCROLL}
  - BLANK_SEG = 7'h7F
  - the 16-entry nibble→segment constant table
- Sub-module hex_seg: combinational, 4-bit nibble in, 7-bit active-low segments out, built on the package table. Instantiated NUM_DIGITS times.
- The controller holds the buffer (register array), prescaler, position counter and FSM.

## Test plan
Bench uses TICK_DIV=4, DEPTH=4, NUM_DIGITS=6.
- Reset: assert reset 2 cycles → hex_out all 7'h7F, busy 0, wr_ready 1, count 0.
- Fill/full: write 1,2,3,4 back-to-back → count 4 and wr_ready 0. A fifth write of 5 is dropped; count stays 4.
- Scroll timing: after the fill, pulse start → HEX0 = 7'h79 ("1") two cycles later. Four cycles after that, HEX1 = 7'h79 and HEX0 = "2".
- Pass end (wrap undefined): same message → busy falls after 9·4 = 36 cycles in SCROLL and hex_out returns to all blank. A second start replays the message.
- Priority: stop asserted on a tick cycle → IDLE next cycle and p does not advance. clear plus wr_valid in IDLE → count 0.
- Wrap (HEX_SCROLL_WRAP_EN defined): after 36 cycles p returns to 0 and busy stays 1. HEX0 shows "1" again.
